mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter XLEN, default 32: operand and result width.
REQ-003 Parameter CHUNK, default 11: multiplier B-port width; number of iterations SHALL be NCH = ceil(XLEN/CHUNK), which is 3 at the defaults.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  controller can accept a request.
REQ-008 funct3  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 rs1  input  XLEN  multiplicand.
REQ-010 rs2  input  XLEN  multiplier.
REQ-011 flush  input  1  synchronous abort of any in-flight operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  XLEN  selected half of the product.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The block SHALL contain exactly one combinational unsigned XLEN x CHUNK array multiplier, time-shared across all iterations.
REQ-017 States SHALL be IDLE, MUL, SIGN and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 Accept SHALL occur when in_valid and in_ready are both high on a rising edge.
- On accept, the block SHALL latch funct3, |rs1| and |rs2| (unsigned magnitudes), and neg = sign(rs1) XOR sign(rs2).
- Signedness: rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only.
- On accept, the block SHALL clear the 2*XLEN-bit accumulator, set k=0, and go to MUL.
REQ-020 Magnitude of -2^(XLEN-1) SHALL be 2^(XLEN-1), represented as an unsigned XLEN-bit value with no overflow.
REQ-021 MUL SHALL drive the multiplier with A=|rs1| and B=chunk k of |rs2|.
- Chunk k is bits [k*CHUNK +: CHUNK], zero-extended above bit XLEN-1.
- Each MUL cycle SHALL perform acc += product << (k*CHUNK), truncated to 2*XLEN bits.
- After k = NCH-1, the block SHALL go to SIGN; otherwise it SHALL increment k.
REQ-022 SIGN SHALL set acc to two's complement of acc when neg is 1, otherwise leave it unchanged.
- SIGN SHALL register result and go to DONE.
REQ-023 result SHALL be acc[XLEN-1:0] for MUL and acc[2*XLEN-1:XLEN] for all other funct3 values.
REQ-024 DONE SHALL hold out_valid=1 and result stable until out_ready=1.
- It SHALL then return to IDLE; there is no DONE-to-MUL bypass.
REQ-025 Latency: with accept at edge 0, out_valid SHALL rise after edge NCH+1 (edge 4 at defaults).
- Throughput SHALL be one operation per NCH+3 cycles when out_ready is held high.
REQ-026 flush SHALL move any state to IDLE on the next edge and clear out_valid.
- flush together with in_valid in IDLE: flush SHALL win and the request SHALL NOT be accepted.
REQ-027 Inputs SHALL be ignored outside the accept cycle; operand changes mid-operation SHALL NOT affect the result.
REQ-028 An operand of zero SHALL still take the full latency, with no early-out.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE and k=0.
- While rst_n=0, acc and result SHALL be 0, out_valid and busy SHALL be 0, and in_ready SHALL be 0.
- in_ready SHALL go to 1 on the first edge after reset release.
REQ-030 Reset asserted mid-operation SHALL discard the operation immediately (asynchronously), with no out_valid pulse.

Verification
REQ-031 MUL, rs1=3, rs2=0xFFFFFFFC -> result 0xFFFFFFF4, out_valid on 4th edge after accept.
REQ-032 MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-033 MULH, 0x80000000 x 0x80000000 -> 0x40000000; MULHSU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 out_ready held low for 10 cycles in DONE -> result stable, in_ready=0 throughout, and a new in_valid is not accepted.
REQ-035 flush in cycle 2 of MUL -> IDLE next edge, no out_valid; then MULHU 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E.
REQ-036 rst_n low mid-MUL -> all outputs 0 immediately; random 10k-operation run against a 64-bit reference model -> zero mismatches.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier controller: one XLEN x CHUNK unsigned multiplier reused over NCH
// cycles on operand magnitudes, then a sign-fix cycle and a held result handshake.
`timescale 1ns/1ps
module mul_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int NCH = (XLEN + CHUNK - 1) / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW  = NCH * CHUNK;
  localparam int PW  = XLEN + CHUNK;
  localparam int AW  = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, SIGN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [AW-1:0]   acc_reg, acc_next;
  logic [XLEN-1:0] a_reg, a_next;
  logic [BW-1:0]   b_reg, b_next;
  logic            neg_reg, neg_next;
  logic [1:0]      funct3_reg, funct3_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            ready_en_reg;

  logic            rs1_neg, rs2_neg, accept;
  logic [XLEN-1:0] mag1, mag2;
  logic [CHUNK-1:0] chunk_arr [NCH];
  logic [CHUNK-1:0] chunk_sel;
  logic [PW-1:0]   product;
  logic [AW-1:0]   prod_ext, acc_fin;

  // in_ready stays low through reset and rises on the first edge after release
  assign in_ready  = (state_reg == IDLE) && ready_en_reg;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;
  assign accept    = in_valid && in_ready && !flush;

  // rs1 signed for MULH/MULHSU, rs2 signed for MULH only
  assign rs1_neg = rs1[XLEN-1] && ((funct3 == 2'b01) || (funct3 == 2'b10));
  assign rs2_neg = rs2[XLEN-1] && (funct3 == 2'b01);
  assign mag1    = rs1_neg ? -rs1 : rs1;
  assign mag2    = rs2_neg ? -rs2 : rs2;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    assign chunk_arr[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  assign chunk_sel = chunk_arr[k_reg];
  assign product   = PW'(a_reg) * PW'(chunk_sel);
  assign prod_ext  = AW'(product);
  assign acc_fin   = neg_reg ? -acc_reg : acc_reg;

  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    acc_next    = acc_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    neg_next    = neg_reg;
    funct3_next = funct3_reg;
    result_next = result_reg;
    if (flush) begin
      state_next = IDLE;
      k_next     = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_next      = mag1;
            b_next      = BW'(mag2);
            neg_next    = rs1_neg ^ rs2_neg;
            funct3_next = funct3;
            acc_next    = '0;
            k_next      = '0;
            state_next  = MUL;
          end
        end
        MUL: begin
          acc_next = acc_reg + (prod_ext << (int'(k_reg) * CHUNK));
          if (k_reg == KW'(NCH - 1)) begin
            state_next = SIGN;
          end else begin
            k_next = k_reg + KW'(1);
          end
        end
        SIGN: begin
          acc_next    = acc_fin;
          result_next = (funct3_reg == 2'b00) ? acc_fin[XLEN-1:0] : acc_fin[AW-1:XLEN];
          state_next  = DONE;
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      acc_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      neg_reg      <= 1'b0;
      funct3_reg   <= '0;
      result_reg   <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      acc_reg      <= acc_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      neg_reg      <= neg_next;
      funct3_reg   <= funct3_next;
      result_reg   <= result_next;
      ready_en_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: vector table, scoreboard queue, handshake/flush/reset
// sequences and a randomized run against a 66-bit signed reference product.
`timescale 1ns/1ps
module tb_mul_seq_ctrl;
  localparam int XLEN = 32;
  localparam int NCH  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  funct3 = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  mul_seq_ctrl #(.XLEN(32), .CHUNK(11)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  int          accept_cyc = 0;
  int          prev_cyc = 0;

  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [32:0] x, y;
    logic signed [65:0] p;
    x = ((f == 2'b01) || (f == 2'b10)) ? {a[31], a} : {1'b0, a};
    y = (f == 2'b01) ? {b[31], b} : {1'b0, b};
    p = 66'(x) * 66'(y);
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      cycle();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  // Drive one request; the accept edge is the next rising edge. Operands are scrambled
  // immediately afterwards so any late sampling shows up as a wrong result.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    wait_ready();
    in_valid = 1'b1;
    funct3   = f;
    rs1      = a;
    rs2      = b;
    cycle();
    sb.push_back(exp);
    accept_cyc = cyc;
    in_valid = 1'b0;
    rs1      = $urandom;
    rs2      = $urandom;
    funct3   = 2'($urandom);
  endtask

  task automatic collect(input string name, input bit check_lat);
    int n = 0;
    logic [31:0] exp;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    if (check_lat) check({name, "_latency"}, 32'(n), 32'(NCH + 1));
    check({name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check(name, result, exp);
    $display("op %s f=%0d result=%h expected=%h latency=%0d", name, dut.funct3_reg, result, exp, n);
    out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFF4};
    vecs[1]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E};
    vecs[6]  = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
    vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[10] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[11] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[12] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};

    // reset values
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    repeat (3) cycle();
    rst_n = 1'b1;
    check("release_in_ready_low", {31'b0, in_ready}, 32'd0);
    cycle();
    check("release_in_ready_high", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // directed vectors, back-to-back with out_ready high
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);
      if (i > 0) check("throughput", 32'(accept_cyc - prev_cyc), 32'(NCH + 3));
      prev_cyc = accept_cyc;
      collect($sformatf("vec%0d", i), 1'b1);
    end

    // consumer stall in DONE: result held, no new accept
    out_ready = 1'b0;
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    for (int n = 0; n < 20 && !out_valid; n++) cycle();
    in_valid = 1'b1;
    funct3   = 2'b00;
    rs1      = 32'd5;
    rs2      = 32'd7;
    for (int n = 0; n < 10; n++) begin
      cycle();
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_result", result, 32'hFFFF_FFFE);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    collect("stall_release", 1'b0);
    check("stall_no_accept_busy", {31'b0, busy}, 32'd0);

    // flush in the second MUL cycle
    issue(2'b11, 32'h0000_0055, 32'h0000_0066, ref_mul(2'b11, 32'h55, 32'h66));
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    void'(sb.pop_back());
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    begin
      logic seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
        cycle();
        if (out_valid) seen = 1'b1;
      end
      check("flush_no_valid_later", {31'b0, seen}, 32'd0);
    end

    // flush beats a request in IDLE
    in_valid = 1'b1;
    flush    = 1'b1;
    cycle();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_request_busy", {31'b0, busy}, 32'd0);

    issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
    collect("after_flush_mulhu", 1'b1);

    // asynchronous reset mid-MUL
    issue(2'b00, 32'd7, 32'd9, 32'd63);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("amid_rst_busy", {31'b0, busy}, 32'd0);
    check("amid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("amid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("amid_rst_result", result, 32'd0);
    cycle();
    check("amid_rst_hold_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    cycle();
    check("amid_rst_release_ready", {31'b0, in_ready}, 32'd1);

    // randomized run against the reference model
    for (int i = 0; i < 10000; i++) begin
      logic [1:0]  f;
      logic [31:0] a, b;
      f = 2'($urandom);
      a = pick();
      b = pick();
      issue(f, a, b, ref_mul(f, a, b));
      if (i > 0) check("rand_throughput", 32'(accept_cyc - prev_cyc), 32'(NCH + 3));
      prev_cyc = accept_cyc;
      collect($sformatf("rand%0d", i), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
